// File: rtl/ahb_slave_mem.sv
// AHB responder backed by a word-organised memory: one data phase in flight, WAIT_STATES
// wait cycles per OKAY transfer, two-cycle ERROR response, registered outputs only.
module ahb_slave_mem #(
  parameter logic [1:0]  SLAVE_ID    = 2'b01,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 1
) (
  input  logic        hClk,
  input  logic        hRst,
  input  logic [1:0]  sel,
  input  logic [31:0] hAddr,
  input  logic        hWrite,
  input  logic [2:0]  hSize,
  input  logic [1:0]  hTrans,
  input  logic        hReady,
  input  logic [31:0] hWdata,
  output logic        hReadyout,
  output logic        hResp,
  output logic [31:0] hRdata
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
  localparam logic [3:0]  WS_LOAD  = 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  idx_q;
  logic [1:0]     lane_q, size_q;
  logic           wr_q, pend_q;
  logic [31:0]    rdata_q;
  logic [31:0]    mem_q [DEPTH];

  logic           accept, acc_err, commit, rd_load;
  logic [AW-1:0]  acc_idx, rd_idx;
  logic [31:0]    wr_word, rd_word;
  logic           unused_trans;

  assign unused_trans = hTrans[0];

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [1:0] sz, input logic [1:0] ln);
    logic [31:0] r;
    r = old_w;
    case (sz)
      2'd0:    r[8*ln +: 8]      = new_w[8*ln +: 8];
      2'd1:    r[16*ln[1] +: 16] = new_w[16*ln[1] +: 16];
      default: r                 = new_w;
    endcase
    return r;
  endfunction

  assign hReadyout = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
  assign hResp     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign hRdata    = rdata_q;

  assign accept  = (sel == SLAVE_ID) && hTrans[1] && hReady && hReadyout;
  assign acc_err = (hSize > 3'd2)
                || ((hSize == 3'd1) && hAddr[0])
                || ((hSize == 3'd2) && (hAddr[1:0] != 2'b00))
                || (hAddr < BASE_ADDR)
                || ({1'b0, hAddr} >= END_ADDR);
  assign acc_idx = AW'((hAddr - BASE_ADDR) >> 2);

  // A write commits at the edge leaving DONE; a read entering DONE on that same edge
  // must see the merged word, so the load path forwards it.
  assign commit  = (state_q == S_DONE) && pend_q && wr_q;
  assign wr_word = merge_lanes(mem_q[idx_q], hWdata, size_q, lane_q);
  assign rd_idx  = (state_q == S_WAIT) ? idx_q : acc_idx;
  assign rd_load = (state_d == S_DONE) && ((state_q == S_WAIT) ? !wr_q : !hWrite);
  assign rd_word = (commit && (idx_q == rd_idx)) ? wr_word : mem_q[rd_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (!accept) begin
          state_d = S_IDLE;
        end else if (acc_err) begin
          state_d = S_ERR1;
        end else if (WAIT_STATES == 0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WS_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge hClk or negedge hRst) begin
    if (!hRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      pend_q  <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q  <= acc_idx;
        lane_q <= hAddr[1:0];
        size_q <= hSize[1:0];
        wr_q   <= hWrite;
        pend_q <= !acc_err;
      end else if (hReadyout) begin
        pend_q <= 1'b0;
      end
      if (rd_load) rdata_q <= rd_word;
      if (commit)  mem_q[idx_q] <= wr_word;
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Drives two responders (WAIT_STATES=1 and WAIT_STATES=0) with directed and random
// transfer streams and compares every cycle against a transfer-level reference model.
module tb_ahb_slave_mem;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 256;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          gap;
  } xfer_t;

  logic        hClk = 1'b0;
  logic        hRst;
  logic [1:0]  sel, hTrans;
  logic [31:0] hAddr, hWdata;
  logic        hWrite, hReady;
  logic [2:0]  hSize;
  logic        rdy0, resp0, rdy1, resp1;
  logic [31:0] rdata0, rdata1;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mdl [2][DEPTH];
  xfer_t       q[$];

  ahb_slave_mem #(.SLAVE_ID(2'b01), .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(1)) dut1 (
    .hClk(hClk), .hRst(hRst), .sel(sel), .hAddr(hAddr), .hWrite(hWrite), .hSize(hSize),
    .hTrans(hTrans), .hReady(hReady), .hWdata(hWdata),
    .hReadyout(rdy1), .hResp(resp1), .hRdata(rdata1));

  ahb_slave_mem #(.SLAVE_ID(2'b11), .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .hClk(hClk), .hRst(hRst), .sel(sel), .hAddr(hAddr), .hWrite(hWrite), .hSize(hSize),
    .hTrans(hTrans), .hReady(hReady), .hWdata(hWdata),
    .hReadyout(rdy0), .hResp(resp0), .hRdata(rdata0));

  initial forever #5 hClk = ~hClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
    longint la, lo, hi;
    int     nb;
    if (s > 3'd2) return 1'b1;
    nb = 1 << s;
    if ((a % nb) != 0) return 1'b1;
    la = {32'd0, a};
    lo = {32'd0, BASE};
    hi = lo + 4 * DEPTH;
    return (la < lo) || (la >= hi);
  endfunction

  task automatic model_write(input int w, input xfer_t t);
    int idx, off, nb;
    idx = int'((t.addr - BASE) / 4);
    off = int'(t.addr % 4);
    nb  = 1 << t.size;
    for (int b = off; b < off + nb; b++) mdl[w][idx][8*b +: 8] = t.wdata[8*b +: 8];
  endtask

  task automatic clear_model();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < DEPTH; i++) mdl[w][i] = '0;
  endtask

  task automatic add(input bit wr, input logic [31:0] a, input logic [2:0] s,
                     input logic [31:0] d, input int gap);
    xfer_t t;
    t.wr = wr; t.addr = a; t.size = s; t.wdata = d; t.gap = gap;
    q.push_back(t);
  endtask

  task automatic idle_inputs();
    sel = 2'b00; hTrans = 2'b00; hAddr = '0; hWrite = 1'b0;
    hSize = 3'd2; hReady = 1'b1; hWdata = '0;
  endtask

  // Address-phase activity that must never turn into a transfer.
  task automatic noise(input bit rdy_exp, input logic [1:0] id);
    hAddr = BASE + ($urandom_range(0, 15) << 2);
    hWrite = 1'b1; hSize = 3'd2; hReady = 1'b1; sel = id; hTrans = 2'b10;
    if (rdy_exp) begin
      case ($urandom_range(0, 2))
        0:       sel    = 2'b10;
        1:       hTrans = {1'b0, 1'($urandom_range(0, 1))};
        default: hReady = 1'b0;
      endcase
    end
  endtask

  // Plays the queued transfers into responder w, pipelining each new address into the
  // cycle where the previous data phase is expected to finish.
  task automatic run(input int w);
    xfer_t      cur, nxt, t;
    bit         act, err, last, pres, erdy, eresp;
    int         k, ws, idx;
    logic [1:0] id;
    ws  = (w == 1) ? 1 : 0;
    id  = (w == 1) ? 2'b01 : 2'b11;
    act = 1'b0; err = 1'b0; k = 0;
    while (act || q.size() > 0) begin
      @(negedge hClk);
      pres = 1'b0; last = 1'b0; erdy = 1'b1; eresp = 1'b0;
      if (act) begin
        if (err) begin
          eresp = 1'b1;
          erdy  = (k == 1);
        end else begin
          erdy = (k == ws);
        end
        last = erdy;
        if (k == 0) hWdata = cur.wdata;
      end
      chk($sformatf("w%0d rdy addr=%h k=%0d", w, cur.addr, k), (w == 1) ? rdy1 : rdy0, erdy);
      chk($sformatf("w%0d resp addr=%h k=%0d", w, cur.addr, k), (w == 1) ? resp1 : resp0, eresp);
      if (act && last && !err) begin
        if (cur.wr) begin
          model_write(w, cur);
        end else begin
          idx = int'((cur.addr - BASE) / 4);
          chk($sformatf("w%0d rdata addr=%h", w, cur.addr), (w == 1) ? rdata1 : rdata0, mdl[w][idx]);
        end
      end
      if (erdy && q.size() > 0 && q[0].gap == 0) begin
        nxt = q.pop_front();
        pres = 1'b1;
        sel = id; hAddr = nxt.addr; hWrite = nxt.wr; hSize = nxt.size; hReady = 1'b1;
        hTrans = {1'b1, 1'($urandom_range(0, 1))};
      end else begin
        if (erdy && q.size() > 0) begin
          t = q[0];
          t.gap--;
          q[0] = t;
        end
        noise(erdy, id);
      end
      if (act && !last) begin
        k++;
      end else if (pres) begin
        cur = nxt; act = 1'b1; k = 0;
        err = is_err(nxt.addr, nxt.size);
      end else begin
        act = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  s;
    int          r;

    hRst = 1'b0;
    idle_inputs();
    clear_model();
    repeat (3) @(negedge hClk);
    chk("reset rdy1", rdy1, 1'b1);
    chk("reset resp1", resp1, 1'b0);
    chk("reset rdata1", rdata1, 32'h0);
    chk("reset rdy0", rdy0, 1'b1);
    chk("reset resp0", resp0, 1'b0);
    chk("reset rdata0", rdata0, 32'h0);
    hRst = 1'b1;

    // Directed word/lane/error sequence on the single-wait-state responder.
    add(0, BASE,            3'd2, 32'h0,          0);
    add(1, BASE + 32'h10,   3'd2, 32'hDEAD_BEEF,  1);
    add(0, BASE + 32'h10,   3'd2, 32'h0,          1);
    add(1, BASE + 32'h13,   3'd0, 32'h5500_0000,  1);
    add(0, BASE + 32'h10,   3'd2, 32'h0,          0);
    add(1, BASE + 32'h10,   3'd1, 32'h0000_1234,  0);
    add(0, BASE + 32'h10,   3'd2, 32'h0,          0);
    add(0, BASE + 32'h2,    3'd2, 32'h0,          0);
    add(1, BASE + 32'h400,  3'd2, 32'hFFFF_FFFF,  0);
    add(1, BASE - 32'h4,    3'd2, 32'hFFFF_FFFF,  1);
    add(1, BASE + 32'h11,   3'd1, 32'hFFFF_FFFF,  0);
    add(0, BASE + 32'h3FC,  3'd2, 32'h0,          0);
    add(0, BASE + 32'h10,   3'd2, 32'h0,          0);
    run(1);

    // Deselected and IDLE writes must complete nothing.
    @(negedge hClk);
    sel = 2'b10; hTrans = 2'b10; hWrite = 1'b1; hAddr = BASE; hSize = 3'd2;
    hReady = 1'b1; hWdata = 32'hFFFF_FFFF;
    @(negedge hClk);
    chk("deselect rdy1", rdy1, 1'b1);
    chk("deselect resp1", resp1, 1'b0);
    sel = 2'b01; hTrans = 2'b00;
    @(negedge hClk);
    chk("idle-trans rdy1", rdy1, 1'b1);
    idle_inputs();
    add(0, BASE, 3'd2, 32'h0, 0);
    run(1);

    // Zero-wait-state write immediately followed by a read of the same word.
    add(1, BASE + 32'h20, 3'd2, 32'hA5A5_A5A5, 0);
    add(0, BASE + 32'h20, 3'd2, 32'h0,         0);
    add(1, BASE + 32'h22, 3'd1, 32'h7E7E_0000, 0);
    add(0, BASE + 32'h20, 3'd2, 32'h0,         0);
    run(0);

    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 120; i++) begin
        r = int'($urandom_range(0, 19));
        if (r == 0)      a = BASE - ($urandom_range(1, 4) << 2);
        else if (r == 1) a = BASE + 32'h400 + $urandom_range(0, 15);
        else if (r == 2) a = BASE + 32'h3F0 + $urandom_range(0, 15);
        else             a = BASE + $urandom_range(0, 63);
        s = 3'($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0) s = 3'($urandom_range(3, 7));
        add(1'($urandom_range(0, 1)), a, s, $urandom, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2)));
      end
      run(w);
    end

    // Reset asserted in the middle of a write's wait state.
    @(negedge hClk);
    sel = 2'b01; hTrans = 2'b10; hWrite = 1'b1; hAddr = BASE + 32'h10; hSize = 3'd2; hReady = 1'b1;
    @(negedge hClk);
    hTrans = 2'b00; hWdata = 32'h1111_2222;
    chk("midreset pre rdy1", rdy1, 1'b0);
    #2 hRst = 1'b0;
    #1;
    chk("midreset rdy1", rdy1, 1'b1);
    chk("midreset resp1", resp1, 1'b0);
    chk("midreset rdata1", rdata1, 32'h0);
    @(negedge hClk);
    hRst = 1'b1;
    idle_inputs();
    clear_model();
    add(0, BASE + 32'h10, 3'd2, 32'h0, 0);
    add(0, BASE + 32'h20, 3'd2, 32'h0, 0);
    run(1);
    add(0, BASE + 32'h20, 3'd2, 32'h0,         0);
    add(1, BASE + 32'h24, 3'd0, 32'h0000_C300, 0);
    add(0, BASE + 32'h24, 3'd2, 32'h0,         0);
    run(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
